// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver and its matching transmitter.
package serial_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // Bit-counter width for a payload of 'bits' bits (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/serial_rx_shreg.sv
// Receive datapath: payload shift register, data-bit counter and running parity.
module serial_rx_shreg
    import serial_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_shift,
    input  logic                 i_par_sample,
    input  logic                 i_ser,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_last,
    output logic                 o_par_err
);

    localparam int unsigned CW = cnt_width(DATA_BITS);

    logic [DATA_BITS-1:0] r_shreg;
    logic [CW-1:0]        r_cnt;
    logic                 r_par;
    logic [DATA_BITS:0]   w_shifted;

    // Serial bit enters at the MSB so the first (LSB) bit ends up at bit 0.
    assign w_shifted = {i_ser, r_shreg};

    // Shift, count and accumulate parity; cleared at each start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
        end else if (i_clear) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
        end else if (i_shift) begin
            r_shreg <= w_shifted[DATA_BITS:1];
            r_cnt   <= r_cnt + CW'(1);
            r_par   <= r_par ^ i_ser;
        end else if (i_par_sample) begin
            r_par   <= r_par ^ i_ser;
        end
    end

    assign o_data    = r_shreg;
    assign o_last    = (r_cnt == CW'(DATA_BITS - 1));
    // Even parity: XOR over data bits and the parity bit must be zero.
    assign o_par_err = r_par;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first data, even parity, stop; one bit per clock.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 SerIn,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 Valid,
    output logic                 ParErr,
    output logic                 FrameErr,
    output logic                 Busy
);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_busy;

    logic                 w_clear;
    logic                 w_shift;
    logic                 w_par_sample;
    logic [DATA_BITS-1:0] w_data;
    logic                 w_last;
    logic                 w_par_err;

    assign w_clear      = (r_state == IDLE) && !SerIn;
    assign w_shift      = (r_state == DATA);
    assign w_par_sample = (r_state == PARITY);

    serial_rx_shreg #(
        .DATA_BITS (DATA_BITS)
    ) u_shreg (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_par_sample (w_par_sample),
        .i_ser        (SerIn),
        .o_data       (w_data),
        .o_last       (w_last),
        .o_par_err    (w_par_err)
    );

    // Frame FSM with registered status pulses, payload and busy flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!SerIn) begin
                        r_state <= DATA;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                DATA: begin
                    r_busy <= 1'b1;
                    if (w_last) begin
                        r_state <= PARITY;
                    end
                end
                PARITY: begin
                    r_busy  <= 1'b1;
                    r_state <= STOP;
                end
                STOP: begin
                    if (SerIn) begin
                        r_data_out <= w_data;
                        r_valid    <= 1'b1;
                        r_par_err  <= w_par_err;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= BREAK;
                        r_busy      <= 1'b1;
                    end
                end
                BREAK: begin
                    if (SerIn) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign DataOut  = r_data_out;
    assign Valid    = r_valid;
    assign ParErr   = r_par_err;
    assign FrameErr = r_frame_err;
    assign Busy     = r_busy;

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter: DATA_BITS, default 8, payload width in bits.
REQ-002 Port: Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: SerIn  input  1  serial line, idle high, one bit per Clk cycle, synchronous to Clk.
REQ-005 Port: DataOut  output  DATA_BITS  last received payload, held until the next good or parity-flagged frame.
REQ-006 Port: Valid  output  1  one-cycle pulse marking a completed frame with a correct stop bit.
REQ-007 Port: ParErr  output  1  one-cycle pulse, coincident with Valid, when the parity check fails.
REQ-008 Port: FrameErr  output  1  one-cycle pulse when the stop bit samples 0.
REQ-009 Port: Busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The frame format SHALL be: start (0), DATA_BITS data bits LSB first, one even-parity bit, stop (1), for DATA_BITS+3 consecutive sampling edges.
REQ-011 The FSM SHALL have the states IDLE, DATA, PARITY, STOP and BREAK.
REQ-012 IDLE: SerIn=0 at an edge -> DATA, bit counter cleared; SerIn=1 -> stay in IDLE.
REQ-013 DATA: each edge shifts SerIn into the payload register from the MSB end; after DATA_BITS samples -> PARITY.
REQ-014 PARITY: the edge samples the parity bit; the error flag SHALL be the XOR of all data bits and the parity bit; -> STOP.
REQ-015 STOP with SerIn=1: DataOut is loaded, Valid=1 for the next cycle, ParErr=1 for the same cycle if parity failed; -> IDLE.
REQ-016 STOP with SerIn=0: FrameErr=1 for one cycle, DataOut unchanged, Valid=0; -> BREAK.
REQ-017 BREAK: stay while SerIn=0; -> IDLE on the first edge with SerIn=1; no start detection in BREAK.
REQ-018 Back-to-back frames: a start bit sampled on the edge immediately after the STOP edge SHALL be accepted with no idle gap required.
REQ-019 Latency: Valid SHALL be asserted in the cycle after the stop-bit edge, DATA_BITS+3 edges after the start-bit edge.
REQ-020 Valid, ParErr and FrameErr SHALL never be high for more than one consecutive cycle per frame.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 On Reset=1, immediately and independent of Clk: state=IDLE, counter=0, shift register=0, DataOut=0, Valid=0, ParErr=0, FrameErr=0, Busy=0.
REQ-023 Reset mid-frame SHALL discard the partial frame with no pulse output; reception resumes at the first SerIn=0 edge after Reset deasserts.

Structure
REQ-024 Package serial_pkg SHALL hold the DATA_BITS default and the state enumeration, shared with the matching transmitter.
REQ-025 One sub-module, serial_rx_shreg, SHALL contain the shift register, the bit counter and the running parity; the FSM and output registers stay in serial_frame_rx.

Verification
REQ-026 Frame 0xA5: send 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 -> DataOut=8'hA5, Valid=1, ParErr=0 for one cycle, 11 edges after the start edge.
REQ-027 Frame 0x01 with parity 0 -> DataOut=8'h01, Valid=1, ParErr=1 in the same cycle.
REQ-028 Frame 0x3C with stop=0, then SerIn held low for 5 cycles, then high -> FrameErr=1 once, DataOut unchanged, no start accepted until SerIn returns high.
REQ-029 Frames 0x3C and 0xC3 sent back-to-back -> two Valid pulses 11 cycles apart with DataOut=8'h3C, then 8'hC3.
REQ-030 Reset pulsed during the 4th data bit of a frame -> all outputs 0 at once, Busy=0, no pulse; the next full frame 0x5A -> Valid with DataOut=8'h5A.
